// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU with an optional iterative multiply/divide engine.
//
// Base ops (0-9: ADD SLL SLT SLTU XOR SRL OR AND SRA SUB) finish one cycle after
// accept. Opcodes 18-31 return 0 with the same latency. Shifts use r2[SHW-1:0].
//
// Optional feature macro: ALU_SEQ_MULDIV_EN
//   defined   : opcodes 10-17 (MUL MULH MULHSU MULHU DIV DIVU REM REMU) run on a
//               radix-2 shift-add multiplier / restoring divider, XLEN+1 cycles
//               from accept to out_valid. Divide-by-zero and signed overflow are
//               resolved in one cycle without iterating.
//   undefined : opcodes 10-17 behave like 18-31 and busy is tied low.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   in_valid   request valid           in_ready   request can be accepted
//   aluop      operation code (5b)     r1, r2     operands (XLEN)
//   out_valid  result valid            out_ready  consumer takes the result
//   out        result, held while out_valid && !out_ready
//   busy       multiply/divide engine iterating
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no result pending, ready for a request
// MUL   | shift-add iterations, counter 0..XLEN-1
// DIV   | restoring-divide iterations, counter 0..XLEN-1
// DONE  | out/out_valid held until out_ready; may accept the next op
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      aluop,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_MUL = 2'd2, S_DIV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

  state_t          state_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_q;
  logic            accept;
  logic [XLEN-1:0] base_res;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;

  always_comb begin
    base_res = '0;
    case (aluop)
      5'd0:    base_res = r1 + r2;
      5'd1:    base_res = r1 << r2[SHW-1:0];
      5'd2:    base_res = {{(XLEN-1){1'b0}}, ($signed(r1) < $signed(r2))};
      5'd3:    base_res = {{(XLEN-1){1'b0}}, (r1 < r2)};
      5'd4:    base_res = r1 ^ r2;
      5'd5:    base_res = r1 >> r2[SHW-1:0];
      5'd6:    base_res = r1 | r2;
      5'd7:    base_res = r1 & r2;
      5'd8:    base_res = $signed(r1) >>> r2[SHW-1:0];
      5'd9:    base_res = r1 - r2;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              busy_q;
  logic              op_mul, op_div, a_sgn, b_sgn, a_neg, b_neg, div_quick;
  logic [XLEN-1:0]   a_mag, b_mag, quick_res;
  logic [2*XLEN-1:0] acc_q, mcand_q, acc_nxt, prod_s;
  logic [XLEN-1:0]   opb_q, quo_q, rem_q, quo_nxt, rem_nxt, quo_s, rem_s;
  logic [XLEN-1:0]   mul_res, div_res;
  logic [XLEN:0]     div_trial;
  logic              div_fits;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, neg_rem_q, sel_q;

  assign busy = busy_q;

  // Operand decode: magnitudes plus the one-cycle divide special cases.
  always_comb begin
    op_mul    = (aluop >= 5'd10) && (aluop <= 5'd13);
    op_div    = (aluop >= 5'd14) && (aluop <= 5'd17);
    a_sgn     = (aluop == 5'd11) || (aluop == 5'd12) || (aluop == 5'd14) || (aluop == 5'd16);
    b_sgn     = (aluop == 5'd11) || (aluop == 5'd14) || (aluop == 5'd16);
    a_neg     = a_sgn && r1[XLEN-1];
    b_neg     = b_sgn && r2[XLEN-1];
    a_mag     = a_neg ? ('0 - r1) : r1;
    b_mag     = b_neg ? ('0 - r2) : r2;
    div_quick = 1'b0;
    quick_res = '0;
    if (r2 == '0) begin
      div_quick = 1'b1;
      quick_res = ((aluop == 5'd14) || (aluop == 5'd15)) ? '1 : r1;
    end else if (((aluop == 5'd14) || (aluop == 5'd16)) && (r1 == MOST_NEG) && (r2 == '1)) begin
      div_quick = 1'b1;
      quick_res = (aluop == 5'd14) ? r1 : '0;
    end
  end

  // One iteration of each engine; the final result is taken from the
  // post-iteration values so the last step and sign fix share one edge.
  always_comb begin
    acc_nxt   = acc_q + (opb_q[0] ? mcand_q : '0);
    prod_s    = neg_q ? ('0 - acc_nxt) : acc_nxt;
    mul_res   = sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    // Shifted partial remainder needs XLEN+1 bits; bit XLEN of the difference is the borrow.
    div_trial = {rem_q, quo_q[XLEN-1]} - {1'b0, opb_q};
    div_fits  = ~div_trial[XLEN];
    rem_nxt   = div_fits ? div_trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    quo_nxt   = {quo_q[XLEN-2:0], div_fits};
    quo_s     = neg_q ? ('0 - quo_nxt) : quo_nxt;
    rem_s     = neg_rem_q ? ('0 - rem_nxt) : rem_nxt;
    div_res   = sel_q ? rem_s : quo_s;
  end
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      busy_q      <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      opb_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      sel_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (op_mul) begin
              state_q     <= S_MUL;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
              acc_q       <= '0;
              mcand_q     <= {{XLEN{1'b0}}, a_mag};
              opb_q       <= b_mag;
              cnt_q       <= '0;
              neg_q       <= a_neg ^ b_neg;
              sel_q       <= (aluop != 5'd10);
            end else if (op_div && !div_quick) begin
              state_q     <= S_DIV;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
              rem_q       <= '0;
              quo_q       <= a_mag;
              opb_q       <= b_mag;
              cnt_q       <= '0;
              neg_q       <= a_neg ^ b_neg;
              neg_rem_q   <= a_neg;
              sel_q       <= (aluop >= 5'd16);
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_q       <= op_div ? quick_res : base_res;
            end
`else
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_q       <= base_res;
`endif
          end else if ((state_q == S_DONE) && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        S_MUL: begin
          acc_q   <= acc_nxt;
          mcand_q <= mcand_q << 1;
          opb_q   <= opb_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_q       <= mul_res;
          end
        end
        S_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_q       <= div_res;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]      aluop;
  logic [XLEN-1:0] r1, r2, out;

  int              n_cmp = 0;
  int              n_err = 0;
  int              cyc = 0;
  bit              rand_rdy = 1'b0;
  logic [XLEN-1:0] sb_q[$];

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .r1(r1), .r2(r2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rand_rdy) begin #1 out_ready = 1'($urandom_range(0, 1)); end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: one pop per output handshake (valid && ready seen between edges).
  always @(negedge clk) begin
    if (reset) sb_q.delete();
    else if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got out_valid with out=0x%08h, want no output", out);
      end else check("scoreboard", out, sb_q.pop_front());
    end
  end

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      5'd0: return a + b;
      5'd1: return a << b[4:0];
      5'd2: return (sa < sb) ? 32'd1 : 32'd0;
      5'd3: return (a < b) ? 32'd1 : 32'd0;
      5'd4: return a ^ b;
      5'd5: return a >> b[4:0];
      5'd6: return a | b;
      5'd7: return a & b;
      5'd8: return 32'(sa >>> b[4:0]);
      5'd9: return a - b;
      default: ;
    endcase
    if (!MD_EN || op > 5'd17) return 32'd0;
    case (op)
      5'd10: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      5'd11: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      5'd12: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      5'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive a request now (just after a rising edge), wait for acceptance, push its result.
  // Returns just after the accept edge with in_valid still high.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, output int acc_cyc);
    int w = 0;
    in_valid = 1'b1;
    aluop = op;
    r1 = a;
    r2 = b;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 after 200 cycles, want 1");
    end else sb_q.push_back(exp);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int ac, lat, nbusy, nrdy;
    send(op, a, b, exp, ac);
    in_valid = 1'b0;
    lat = 1;
    nbusy = 0;
    nrdy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      nbusy += int'(busy);
      nrdy += int'(in_ready);
      lat++;
      @(negedge clk);
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_busy"}, nbusy, exp_lat - 1);
    check({name, "_rdy"}, nrdy, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_slow(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!MD_EN || op < 5'd10 || op > 5'd17) return 1'b0;
    if (op >= 5'd14 && b == 0) return 1'b0;
    if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int ac[4];
    int w, nvalid;
    logic [31:0] e, a, b;
    logic [4:0] op;

    tbl.push_back('{5'd0,  32'd5,          32'd7,          32'd12});
    tbl.push_back('{5'd1,  32'd1,          32'h24,         32'h10});
    tbl.push_back('{5'd2,  32'hFFFF_FFFF,  32'd1,          32'd1});
    tbl.push_back('{5'd3,  32'hFFFF_FFFF,  32'd1,          32'd0});
    tbl.push_back('{5'd4,  32'hF0F0,       32'hFF00,       32'h0FF0});
    tbl.push_back('{5'd5,  32'h8000_0000,  32'd31,         32'd1});
    tbl.push_back('{5'd6,  32'hA,          32'h5,          32'hF});
    tbl.push_back('{5'd7,  32'hC,          32'hA,          32'h8});
    tbl.push_back('{5'd8,  32'h8000_0000,  32'h21,         32'hC000_0000});
    tbl.push_back('{5'd9,  32'd3,          32'd5,          32'hFFFF_FFFE});
    tbl.push_back('{5'd20, 32'd5,          32'd7,          32'd0});
    tbl.push_back('{5'd31, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0});
    tbl.push_back('{5'd10, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD});
    tbl.push_back('{5'd11, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000});
    tbl.push_back('{5'd12, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF});
    tbl.push_back('{5'd13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE});
    tbl.push_back('{5'd14, 32'd7,          32'd0,          32'hFFFF_FFFF});
    tbl.push_back('{5'd16, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0});
    tbl.push_back('{5'd14, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
    tbl.push_back('{5'd15, 32'd5,          32'd0,          32'hFFFF_FFFF});
    tbl.push_back('{5'd17, 32'd9,          32'd0,          32'd9});
    tbl.push_back('{5'd14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
    tbl.push_back('{5'd16, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
    tbl.push_back('{5'd14, 32'h8000_0000,  32'd1,          32'h8000_0000});

    // reset values
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    aluop = '0; r1 = '0; r2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;

    // ADD 5+7: valid one cycle after accept, in_ready stays high
    send(5'd0, 32'd5, 32'd7, 32'd12, ac[0]);
    in_valid = 1'b0;
    @(negedge clk);
    check("add_valid", out_valid, 1'b1);
    check("add_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // four back-to-back base ops under continuous out_ready
    send(5'd0, 32'd1,  32'd2, 32'd3, ac[0]);
    send(5'd9, 32'd10, 32'd4, 32'd6, ac[1]);
    send(5'd4, 32'd3,  32'd5, 32'd6, ac[2]);
    send(5'd6, 32'd8,  32'd1, 32'd9, ac[3]);
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) check($sformatf("b2b_gap%0d", i), ac[i] - ac[0], i);
    @(negedge clk);
    check("b2b_last_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;

    // vector table
    foreach (tbl[i]) begin
      e = (!MD_EN && tbl[i].op >= 5'd10 && tbl[i].op <= 5'd17) ? 32'd0 : tbl[i].exp;
      run_one($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, e,
              is_slow(tbl[i].op, tbl[i].a, tbl[i].b) ? XLEN + 1 : 1);
    end

    // DIVU 100/7 with the consumer stalled for 5 cycles; a waiting ADD must not be taken
    out_ready = 1'b0;
    send(5'd15, 32'd100, 32'd7, MD_EN ? 32'd14 : 32'd0, ac[0]);
    aluop = 5'd0; r1 = 32'd1; r2 = 32'd2;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 100) begin
      w++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_out", out, MD_EN ? 32'd14 : 32'd0);
      check("hold_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    run_one("remu", 5'd17, 32'd100, 32'd7, MD_EN ? 32'd2 : 32'd0, MD_EN ? XLEN + 1 : 1);

    // reset 10 cycles into a multiply
    send(5'd10, 32'd3, 32'd5, MD_EN ? 32'd15 : 32'd0, ac[0]);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mul_busy_mid", busy, MD_EN);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    nvalid = 0;
    repeat (XLEN + 5) begin
      nvalid += int'(out_valid);
      @(negedge clk);
    end
    check("abort_no_valid", nvalid, 0);
    @(posedge clk);
    #1;
    run_one("add_after_abort", 5'd0, 32'd1, 32'd1, 32'd2, 1);

    // random ops against the model with a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      send(op, a, b, model(op, a, b), ac[0]);
      if ($urandom_range(0, 2) == 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    check("drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Executes the 10 base RV32I ALU ops with one-cycle registered latency.
- Adds the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative multiply/divide engine.
- Sits between decode/operand-fetch and writeback; the pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, datapath width in bits (power of two, ≥8).
- SHW, $clog2(XLEN), shift-amount width; r2[SHW-1:0] is used for shifts.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request this cycle.
- aluop  input  5  operation code.
- r1  input  XLEN  operand 1.
- r2  input  XLEN  operand 2.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  XLEN  result, held stable while out_valid && !out_ready.
- busy  output  1  iterative engine active (state MUL or DIV).

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE; out_valid=0; out=0; busy=0; in_ready=1.
- Opcodes 0–9, same as the base ALU:
  - 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SRA, 9 SUB.
  - Shifts use only r2[SHW-1:0].
- Opcodes 10–17: 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
- Opcodes 18–31: result 0, treated as base ops (1-cycle).
- Accept condition: in_valid && in_ready; operands and aluop are captured at that edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- States:
  - IDLE:
    - accept base op -> DONE, out computed combinationally and registered at that edge.
    - accept MUL* -> MUL.
    - accept DIV*/REM* -> DIV.
  - MUL: radix-2 shift-add on |operands| (signedness per op), counter 0..XLEN-1. After XLEN cycles, sign-correct, select low (MUL) or high XLEN bits -> DONE.
  - DIV: restoring divide on magnitudes, XLEN iterations, sign-correct (quotient sign = r1^r2 sign, remainder sign = r1 sign) -> DONE.
  - DONE:
    - out_valid=1.
    - out_ready && in_valid -> accept next request (as IDLE).
    - out_ready && !in_valid -> IDLE.
    - !out_ready -> hold.
- Latency from accept edge to out_valid: base ops 1 cycle; mul/div XLEN+1 cycles.
- Back-to-back base ops under continuous out_ready: throughput 1/cycle.
- Divide boundary rules, resolved in 1 cycle (IDLE -> DONE, no iteration):
  - r2==0: DIV/DIVU -> all ones; REM/REMU -> r1.
  - Signed overflow (r1 = most negative, r2 = -1): DIV -> r1; REM -> 0.
- busy=1 exactly in MUL/DIV; in_ready=0 while busy.
- in_valid while busy is ignored and not queued; the requester holds it.
- Reset asserted mid-iteration: aborts at that edge; next cycle matches reset values, and no out_valid is issued for the aborted op.
- All arithmetic is modulo 2^XLEN; the product is internally 2*XLEN wide.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: M-extension ops as above.
- Undefined:
  - Multiply/divide engine and the MUL/DIV states are omitted.
  - Opcodes 10–17 behave like 18–31 (result 0, 1-cycle latency).
  - busy is tied 0.

Test Plan:
- reset, then ADD r1=5 r2=7, out_ready=1 -> out_valid 1 cycle after accept, out=12; in_ready stays 1; 4 back-to-back ops complete in 4 consecutive cycles.
- SRA r1=0x80000000 r2=0x21 (XLEN=32) -> shift uses 1 -> out=0xC0000000; SLT r1=-1 r2=1 -> 1; SLTU same operands -> 0.
- MULH r1=0x80000000 r2=0x80000000 -> out=0x40000000 after 33 cycles; busy high 32 cycles; in_ready low throughout.
- DIV r1=7 r2=0 -> 0xFFFFFFFF after 1 cycle; REM r1=0x80000000 r2=0xFFFFFFFF -> 0; DIV with the same operands -> 0x80000000.
- DIVU r1=100 r2=7 -> 14; REMU -> 2; hold out_ready=0 for 5 cycles -> out/out_valid stable, no new accept.
- Assert reset 10 cycles into MUL -> out_valid=0, busy=0, in_ready=1 next cycle; a subsequent ADD 1+1 returns 2.
